bios_loader: RTL

BIOS_LOADER -- requirements
Module: bios_loader

---
 rtl/bios_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bios_loader.sv
// BIOS image loader: packs the hps_io byte download stream into 16-bit words,
// buffers them in a small FIFO and hands them to the system one word per
// bios_req, raising bios_loaded once the image is complete.
module bios_loader #(
    parameter logic [7:0] BIOS_INDEX = 8'd0,
    parameter int         BIOS_WORDS = 8192,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    input  logic        bios_req,
    output logic [12:0] bios_addr,
    output logic [15:0] bios_din,
    output logic        bios_wr,
    output logic        bios_loaded
);

    localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(BIOS_WORDS + 1);

    localparam logic [24:0]    BYTE_LIMIT = 25'(2 * BIOS_WORDS);
    localparam logic [CW-1:0]  FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  WAIT_CNT   = CW'(FIFO_DEPTH - 1);
    localparam logic [WCW-1:0] WORD_LIMIT = WCW'(BIOS_WORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]     rst_sync;
    logic           rst_int_n;
    logic [1:0]     state, state_d;
    logic           act_q;
    logic           active, dl_rise, dl_fall, load_entry;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [15:0]    mem [FIFO_DEPTH];
    logic           fifo_empty, fifo_full;
    logic [7:0]     lo_byte;
    logic           lo_valid;
    logic           pad_pend;
    logic [WCW-1:0] words_cnt;
    logic           limit_hit;
    logic           busy;
    logic           in_range, byte_wr, lo_wr, hi_wr, pad_go;
    logic           push_req, push_ok, issue;
    logic [15:0]    push_data;
    logic           ovf;

    assign rst_int_n  = rst_sync[1];
    assign active     = ioctl_download && (ioctl_index == BIOS_INDEX);
    assign dl_rise    = active && !act_q;
    assign dl_fall    = !active && act_q;
    assign load_entry = dl_rise && (state != LOAD);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign limit_hit  = (words_cnt == WORD_LIMIT);
    assign busy       = (state == LOAD) || (state == DRAIN);
    assign ioctl_wait = (count >= WAIT_CNT);

    // Reset asserts immediately, release is re-timed to two clk_sys edges.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Byte stream decode, FIFO push/pop requests and next state.
    always_comb begin
        in_range  = (ioctl_addr < BYTE_LIMIT);
        byte_wr   = (state == LOAD) && active && ioctl_wr && in_range;
        lo_wr     = byte_wr && !ioctl_addr[0];
        hi_wr     = byte_wr && ioctl_addr[0];
        pad_go    = (state == DRAIN) && pad_pend && !fifo_full && !load_entry;
        push_req  = hi_wr || pad_go;
        push_ok   = push_req && !fifo_full;
        push_data = hi_wr ? {ioctl_dout, lo_byte} : {8'h00, lo_byte};
        issue     = busy && bios_req && !fifo_empty && !limit_hit && !load_entry;
        state_d   = state;
        if (load_entry) begin
            state_d = LOAD;
        end else if ((state == LOAD) && dl_fall) begin
            state_d = DRAIN;
        end else if ((state == DRAIN) && fifo_empty && !pad_pend) begin
            state_d = DONE;
        end
    end

    // FIFO storage; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Control state, FIFO pointers, byte latch and output word registers.
    always_ff @(posedge clk_sys or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= IDLE;
            act_q       <= 1'b1;  // a download already running at release is not a rising edge
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            lo_byte     <= 8'h00;
            lo_valid    <= 1'b0;
            pad_pend    <= 1'b0;
            words_cnt   <= '0;
            bios_addr   <= 13'd0;
            bios_din    <= 16'h0000;
            bios_wr     <= 1'b0;
            bios_loaded <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            act_q <= active;
            state <= state_d;
            ovf   <= ovf | (push_req && fifo_full);
            if (load_entry) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                lo_byte     <= 8'h00;
                lo_valid    <= 1'b0;
                pad_pend    <= 1'b0;
                words_cnt   <= '0;
                bios_addr   <= 13'd0;
                bios_wr     <= 1'b0;
                bios_loaded <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (issue) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    bios_din  <= mem[rd_ptr];
                    words_cnt <= words_cnt + 1'b1;
                end
                count <= count + CW'(push_ok) - CW'(issue);

                if (lo_wr) begin
                    lo_byte  <= ioctl_dout;
                    lo_valid <= 1'b1;
                end else if (hi_wr) begin
                    lo_valid <= 1'b0;
                end else if ((state == LOAD) && dl_fall) begin
                    pad_pend <= lo_valid;
                    lo_valid <= 1'b0;
                end else if (pad_go) begin
                    pad_pend <= 1'b0;
                end

                // Address of a pulse is held during it and advances afterwards.
                bios_wr <= issue;
                if (bios_wr) begin
                    bios_addr <= bios_addr + 13'd1;
                end

                if ((state_d == DONE) || (busy && limit_hit && fifo_empty)) begin
                    bios_loaded <= 1'b1;
                end
            end
        end
    end

endmodule
